// File: rtl/quant_sequencer.sv
// Block quantizer: captures a BLOCK_SIZE x BLOCK_SIZE coefficient block and streams it out shifted by a per-entry table.
// Optional `ZIGZAG_EN selects zigzag emission order; the default build emits raster order.
module quant_sequencer #(
  parameter int BLOCK_SIZE    = 8,
  parameter int DCT_OUT_WIDTH = 52,
  parameter int SHIFT_WIDTH   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DCT_OUT_WIDTH-1:0] in_block [BLOCK_SIZE][BLOCK_SIZE],
  input  logic                            tbl_wr_en,
  input  logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] tbl_wr_addr,
  input  logic [SHIFT_WIDTH-1:0]          tbl_wr_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DCT_OUT_WIDTH-1:0] out_coeff,
  output logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] out_index,
  output logic                            out_last,
  output logic                            busy
);
  // state | meaning
  // IDLE  | waiting for a block; shift-table writes allowed
  // RUN   | output registers hold coefficient pos; advance on out_ready
  localparam int N     = BLOCK_SIZE * BLOCK_SIZE;
  localparam int IDX_W = $clog2(N);
  localparam int RC_W  = $clog2(BLOCK_SIZE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(BLOCK_SIZE - 1);
  localparam logic [IDX_W-1:0] POS_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] POS_PEN  = IDX_W'(N - 2);

  logic [0:0]                     state_q;
  logic [RC_W-1:0]                row_q, col_q, row_nx, col_nx;
  logic [IDX_W-1:0]               pos_q, idx_nx;
  logic signed [DCT_OUT_WIDTH-1:0] blk_q [N];
  logic [SHIFT_WIDTH-1:0]         tbl_q [N];
  logic                           accept;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_RUN);
  assign accept    = in_valid && (state_q == S_IDLE);
  assign idx_nx    = IDX_W'(row_nx) * IDX_W'(BLOCK_SIZE) + IDX_W'(col_nx);

  // Walker: next (row,col) after the coefficient currently presented.
  always_comb begin
    row_nx = row_q;
    col_nx = col_q;
`ifdef ZIGZAG_EN
    if (row_q[0] == col_q[0]) begin
      if (col_q == RC_LAST) row_nx = row_q + RC_ONE;
      else if (row_q == '0) col_nx = col_q + RC_ONE;
      else begin
        row_nx = row_q - RC_ONE;
        col_nx = col_q + RC_ONE;
      end
    end else begin
      if (row_q == RC_LAST) col_nx = col_q + RC_ONE;
      else if (col_q == '0) row_nx = row_q + RC_ONE;
      else begin
        row_nx = row_q + RC_ONE;
        col_nx = col_q - RC_ONE;
      end
    end
`else
    if (col_q == RC_LAST) begin
      col_nx = '0;
      row_nx = row_q + RC_ONE;
    end else begin
      col_nx = col_q + RC_ONE;
    end
`endif
  end

  // Block storage carries no reset; it is only read while RUN after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < BLOCK_SIZE; r++)
        for (int c = 0; c < BLOCK_SIZE; c++)
          blk_q[r*BLOCK_SIZE + c] <= in_block[r][c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      pos_q     <= '0;
      out_coeff <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_RUN;
            row_q     <= '0;
            col_q     <= '0;
            pos_q     <= '0;
            out_coeff <= in_block[0][0] >>> tbl_q[0];
            out_index <= '0;
            out_last  <= (N == 1);
          end else if (tbl_wr_en) begin
            tbl_q[tbl_wr_addr] <= tbl_wr_data;
          end
        end
        default: begin
          if (out_ready) begin
            if (pos_q == POS_LAST) begin
              state_q  <= S_IDLE;
              out_last <= 1'b0;
            end else begin
              row_q     <= row_nx;
              col_q     <= col_nx;
              pos_q     <= pos_q + IDX_W'(1);
              out_coeff <= blk_q[idx_nx] >>> tbl_q[idx_nx];
              out_index <= idx_nx;
              out_last  <= (pos_q == POS_PEN);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_quant_sequencer.sv
// Directed bench for quant_sequencer: pass-through, shift math, backpressure, table gating, mid-block reset.
module tb_quant_sequencer;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [51:0] in_block [8][8];
  logic               tbl_wr_en;
  logic [5:0]         tbl_wr_addr;
  logic [2:0]         tbl_wr_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [51:0] out_coeff;
  logic [5:0]         out_index;
  logic               out_last;
  logic               busy;

  int checks = 0;
  int failures = 0;

  logic signed [51:0] model_blk [64];
  logic [2:0]         model_tbl [64];
  int                 order [64];

  quant_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [51:0] exp_coeff(input int i);
    return model_blk[i] >>> model_tbl[i];
  endfunction

  task automatic tbl_write(input int addr, input int data);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 6'(addr);
    tbl_wr_data = 3'(data);
    @(negedge clk);
    tbl_wr_en = 1'b0;
    model_tbl[addr] = 3'(data);
  endtask

  task automatic send_block(input bit wr_same);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_block[r][c] = model_blk[r*8 + c];
    chk("in_ready_idle", in_ready, 1);
    chk("out_valid_idle", out_valid, 0);
    chk("busy_idle", busy, 0);
    in_valid = 1'b1;
    if (wr_same) begin
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = 6'd1;
      tbl_wr_data = 3'd7;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    tbl_wr_en = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_block[r][c] = 52'sh5A5A5;
  endtask

  task automatic drain(input bit bp, input int n_out, input bit busy_wr);
    int k = 0;
    int cyc = 0;
    while (k < n_out && cyc < 400) begin
      out_ready   = bp ? (cyc % 3 == 0) : 1'b1;
      tbl_wr_en   = busy_wr && (cyc == 3);
      tbl_wr_addr = 6'd0;
      tbl_wr_data = 3'd7;
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("in_ready_run", in_ready, 0);
      chk("out_index", out_index, order[k]);
      chk("out_coeff", out_coeff, exp_coeff(order[k]));
      chk("out_last", out_last, k == 63);
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    tbl_wr_en = 1'b0;
    chk("drain_count", k, n_out);
  endtask

  task automatic check_idle_after();
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
`ifdef ZIGZAG_EN
    int zz [64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,
                    7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,
                    39,46,53,60,61,54,47,55,62,63};
    for (int i = 0; i < 64; i++) order[i] = zz[i];
`else
    for (int i = 0; i < 64; i++) order[i] = i;
`endif
    for (int i = 0; i < 64; i++) model_tbl[i] = 3'd0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_block[r][c] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coeff", out_coeff, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Default table passes values straight through.
    for (int i = 0; i < 64; i++) model_blk[i] = 52'(i - 32);
    send_block(1'b0);
    drain(1'b0, 64, 1'b0);
    check_idle_after();

    // Shift math with backpressure, including sign and full-width extremes.
    tbl_write(5, 3);
    tbl_write(10, 1);
    tbl_write(62, 7);
    tbl_write(63, 7);
    for (int i = 0; i < 64; i++) model_blk[i] = 52'(i * 37 - 1000);
    model_blk[5]  = -52'sd9;
    model_blk[10] = -52'sd7;
    model_blk[62] = 52'sh7FFFFFFFFFFFF;
    model_blk[63] = 52'sh8000000000000;
    send_block(1'b0);
    drain(1'b1, 64, 1'b0);
    check_idle_after();

    // Positive shift; write alongside accept and write while busy both dropped.
    for (int i = 0; i < 64; i++) model_blk[i] = 52'(500 - i * 11);
    model_blk[5] = 52'sd9;
    model_blk[1] = 52'sd100;
    send_block(1'b1);
    drain(1'b0, 64, 1'b1);
    check_idle_after();

    for (int i = 0; i < 64; i++) model_blk[i] = 52'((i % 2 == 1) ? -(i * 1001) : i * 999);
    model_blk[0] = 52'sd128;
    model_blk[1] = 52'sd100;
    send_block(1'b0);
    drain(1'b0, 64, 1'b0);
    check_idle_after();

    // Same write now lands because the block is idle.
    tbl_write(0, 7);
    send_block(1'b0);
    drain(1'b0, 64, 1'b0);
    check_idle_after();

    // Mid-block reset clears outputs at once and reverts the table.
    send_block(1'b0);
    drain(1'b0, 10, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_out_last", out_last, 0);
    for (int i = 0; i < 64; i++) model_tbl[i] = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_blk[5] = -52'sd9;
    send_block(1'b0);
    drain(1'b1, 64, 1'b0);
    check_idle_after();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
